// File: rtl/heap_topk_ctrl_if.sv
// Stream, heap-side and result signals of the top-K frame sequencer.
// slave: the sequencer; master: the producer/heap/consumer side.
interface heap_topk_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-3:0] s_data;
  logic                  s_last;
  logic [DATA_WIDTH-1:0] heap_din;
  logic                  heap_en;
  logic                  heap_init;
  logic                  heap_flush;
  logic [DATA_WIDTH-1:0] heap_dout;
  logic                  heap_valid;
  logic                  m_valid;
  logic [DATA_WIDTH-3:0] m_data;

  modport master (
    output s_valid, s_data, s_last,
    output heap_dout, heap_valid,
    input  s_ready, heap_din, heap_en,
    input  heap_init, heap_flush,
    input  m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    input  heap_dout, heap_valid,
    output s_ready, heap_din, heap_en,
    output heap_init, heap_flush,
    output m_valid, m_data
  );
endinterface

// File: rtl/heap_topk_ctrl.sv
// Frame sequencer for the streaming top-K heap: init, paced
// insert, drain, flush and forward of the K largest items.
module heap_topk_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int KEY_WIDTH    = 8,
  parameter int NLEVELS      = 2,
  parameter int INSERT_GAP   = 2,
  parameter int INIT_CYCLES  = 2**(NLEVELS+1),
  parameter int DRAIN_CYCLES = 2*NLEVELS + 2,
  parameter int FLUSH_CYCLES = 2*(2**(NLEVELS+1)-1) + 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  heap_topk_ctrl_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] in_count,
  output logic [CNT_WIDTH-1:0] evict_count,
  output logic [CNT_WIDTH-1:0] out_count
);
  localparam int PW =
    $clog2(INIT_CYCLES + DRAIN_CYCLES + FLUSH_CYCLES + 1);
  localparam int GW = $clog2(INSERT_GAP + 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    IDLE, INIT, LOAD, DRAIN, FLUSH, DONE
  } state_t;

  state_t                state, state_n;
  logic [PW-1:0]         phase, phase_n;
  logic [GW-1:0]         gap, gap_n;
  logic                  aborted, aborted_n;
  logic                  s_ready_n;
  logic                  en_n;
  logic                  init_n;
  logic                  flush_n;
  logic                  m_valid_n;
  logic                  busy_n;
  logic                  done_n;
  logic [DATA_WIDTH-1:0] din_n;
  logic [DATA_WIDTH-3:0] m_data_n;
  logic [CNT_WIDTH-1:0]  in_n, ev_n, out_n;
  logic                  accept;
  logic                  unused_flag;

  // The heap's flag bits carry nothing the sequencer needs.
  assign unused_flag = ^bus.heap_dout[DATA_WIDTH-1 -: 2];
  assign accept      = bus.s_valid & bus.s_ready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    gap_n     = '0;
    aborted_n = aborted;
    en_n      = 1'b0;
    flush_n   = 1'b0;
    m_valid_n = 1'b0;
    done_n    = 1'b0;
    din_n     = bus.heap_din;
    m_data_n  = bus.m_data;
    in_n      = in_count;
    ev_n      = evict_count;
    out_n     = out_count;
    if (state != IDLE && abort) begin
      // Re-init the heap so a half-loaded frame leaves nothing behind.
      state_n   = INIT;
      phase_n   = '0;
      aborted_n = 1'b1;
      in_n      = '0;
      ev_n      = '0;
      out_n     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n   = INIT;
            phase_n   = '0;
            aborted_n = 1'b0;
            in_n      = '0;
            ev_n      = '0;
            out_n     = '0;
          end
        end
        INIT: begin
          if (phase == PW'(INIT_CYCLES - 1)) begin
            state_n = aborted ? IDLE : LOAD;
            phase_n = '0;
          end else begin
            phase_n = phase + 1'b1;
          end
        end
        LOAD: begin
          if (bus.heap_valid) ev_n = sat_inc(evict_count);
          if (gap != '0) gap_n = gap - 1'b1;
          if (accept) begin
            en_n  = 1'b1;
            din_n = {2'b00,
                     bus.s_data[DATA_WIDTH-3:KEY_WIDTH],
                     bus.s_data[KEY_WIDTH-1:0]};
            in_n  = sat_inc(in_count);
            gap_n = GW'(INSERT_GAP - 1);
            if (bus.s_last) begin
              state_n = DRAIN;
              phase_n = '0;
            end
          end
        end
        DRAIN: begin
          if (bus.heap_valid) ev_n = sat_inc(evict_count);
          if (phase == PW'(DRAIN_CYCLES - 1)) begin
            state_n = FLUSH;
            phase_n = '0;
            flush_n = 1'b1;
          end else begin
            phase_n = phase + 1'b1;
          end
        end
        FLUSH: begin
          m_valid_n = bus.heap_valid;
          if (bus.heap_valid) begin
            m_data_n = bus.heap_dout[DATA_WIDTH-3:0];
            out_n    = sat_inc(out_count);
          end
          if (phase == PW'(FLUSH_CYCLES - 1)) begin
            state_n = DONE;
            phase_n = '0;
          end else begin
            phase_n = phase + 1'b1;
          end
        end
        DONE: begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
    s_ready_n = (state_n == LOAD) && (gap_n == '0);
    init_n    = (state_n == INIT);
    busy_n    = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      phase          <= '0;
      gap            <= '0;
      aborted        <= 1'b0;
      bus.s_ready    <= 1'b0;
      bus.heap_en    <= 1'b0;
      bus.heap_din   <= '0;
      bus.heap_init  <= 1'b0;
      bus.heap_flush <= 1'b0;
      bus.m_valid    <= 1'b0;
      bus.m_data     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      in_count       <= '0;
      evict_count    <= '0;
      out_count      <= '0;
    end else begin
      state          <= state_n;
      phase          <= phase_n;
      gap            <= gap_n;
      aborted        <= aborted_n;
      bus.s_ready    <= s_ready_n;
      bus.heap_en    <= en_n;
      bus.heap_din   <= din_n;
      bus.heap_init  <= init_n;
      bus.heap_flush <= flush_n;
      bus.m_valid    <= m_valid_n;
      bus.m_data     <= m_data_n;
      busy           <= busy_n;
      done           <= done_n;
      in_count       <= in_n;
      evict_count    <= ev_n;
      out_count      <= out_n;
    end
  end
endmodule

// File: tb/tb_heap_topk_ctrl.sv
// Bench for heap_topk_ctrl: behavioural top-K heap plus a
// frame-level model of the forwarded result.
`timescale 1ns/1ps
module tb_heap_topk_ctrl;
  localparam int DW = 16;
  localparam int KW = 8;
  localparam int HS = 7;
  localparam int CW = 16;
  typedef logic [DW-3:0] item_t;
  typedef item_t item_q_t[$];

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  logic [CW-1:0] in_count, evict_count, out_count;

  heap_topk_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  heap_topk_ctrl #(
    .DATA_WIDTH(DW), .KEY_WIDTH(KW), .NLEVELS(2),
    .INSERT_GAP(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .bus(bus), .busy(busy), .done(done),
    .in_count(in_count), .evict_count(evict_count),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic item_t mk(input int p, input int k);
    return {p[5:0], k[7:0]};
  endfunction

  // Reference result: the K largest keys, ascending.
  function automatic item_q_t topk(input item_q_t a);
    item_q_t r;
    item_q_t w;
    int bi;
    w = a;
    while (w.size() > 0 && r.size() < HS) begin
      bi = 0;
      foreach (w[i]) if (w[i][KW-1:0] > w[bi][KW-1:0]) bi = i;
      r.push_front(w[bi]);
      w.delete(bi);
    end
    return r;
  endfunction

  // Behavioural heap: keeps HS largest, ejects smaller on overflow.
  logic [DW-1:0] hq[$];
  logic [DW-1:0] oq[$];
  int hmi;
  always @(posedge clk or negedge rstn) begin : heap_model
    if (!rstn) begin
      hq.delete();
      oq.delete();
      bus.heap_valid <= 1'b0;
      bus.heap_dout  <= '0;
    end else if (bus.heap_init) begin
      hq.delete();
      oq.delete();
      bus.heap_valid <= 1'b0;
    end else begin
      if (oq.size() > 0) begin
        bus.heap_valid <= 1'b1;
        bus.heap_dout  <= oq.pop_front();
      end else begin
        bus.heap_valid <= 1'b0;
      end
      if (bus.heap_en) begin
        if (hq.size() < HS) begin
          hq.push_back(bus.heap_din);
        end else begin
          hmi = 0;
          foreach (hq[i]) if (hq[i][KW-1:0] < hq[hmi][KW-1:0]) hmi = i;
          if (bus.heap_din[KW-1:0] <= hq[hmi][KW-1:0]) begin
            oq.push_back(bus.heap_din);
          end else begin
            oq.push_back(hq[hmi]);
            hq[hmi] = bus.heap_din;
          end
        end
      end
      if (bus.heap_flush) begin
        while (hq.size() > 0) begin
          hmi = 0;
          foreach (hq[i]) if (hq[i][KW-1:0] < hq[hmi][KW-1:0]) hmi = i;
          oq.push_back(hq[hmi]);
          hq.delete(hmi);
        end
      end
    end
  end

  item_q_t acc, exp_q, got_q;
  int acc_cyc[$];
  logic en_pend = 1'b0;
  logic prev_en = 1'b0;
  logic [DW-1:0] din_exp = '0;
  item_t exp_item;
  int done_seen = 0;
  int done_cyc = 0;
  int flush_cyc = 0;
  int init_run = 0;
  int init_len = 0;
  int last_acc_cyc = 0;
  int mo, mn;

  always @(negedge clk) begin : monitor
    if (!rstn) begin
      en_pend  = 1'b0;
      prev_en  = 1'b0;
      init_run = 0;
      exp_q.delete();
    end else begin
      chk("heap_en", bus.heap_en, en_pend);
      if (en_pend) chk("heap_din", bus.heap_din, din_exp);
      chk("en_and_flush", bus.heap_en & bus.heap_flush, 1'b0);
      chk("en_back_to_back", bus.heap_en & prev_en, 1'b0);
      prev_en = bus.heap_en;
      if (bus.heap_init) begin
        acc.delete();
        init_run++;
      end else if (init_run > 0) begin
        init_len = init_run;
        init_run = 0;
      end
      en_pend = bus.s_valid & bus.s_ready;
      if (en_pend) begin
        din_exp = {2'b00, bus.s_data};
        acc.push_back(bus.s_data);
        acc_cyc.push_back(cyc);
      end
      if (bus.heap_flush) begin
        exp_q = topk(acc);
        flush_cyc = cyc;
      end
      if (bus.m_valid) begin
        if (exp_q.size() > 0) exp_item = exp_q.pop_front();
        else exp_item = 'x;
        chk("m_data", bus.m_data, exp_item);
        got_q.push_back(bus.m_data);
      end
      if (done) begin
        mn = acc.size();
        mo = (mn < HS) ? mn : HS;
        chk("in_count", in_count, mn);
        chk("out_count", out_count, mo);
        chk("evict_count", evict_count, mn - mo);
        chk("m_missing", exp_q.size(), 0);
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {bus.s_ready, bus.heap_en, bus.heap_init,
        bus.heap_flush, bus.m_valid, busy, done}, '0);
    chk({tag, "_din"}, bus.heap_din, '0);
    chk({tag, "_mdata"}, bus.m_data, '0);
    chk({tag, "_cnt"}, {in_count, evict_count, out_count}, '0);
  endtask

  task automatic begin_frame();
    int k;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("init_on_start", bus.heap_init, 1'b1);
    k = 1;
    while (!bus.s_ready && k < 50) begin
      tick();
      k++;
    end
    chk("first_ready_latency", k, 9);
  endtask

  task automatic push_item(input item_t d, input logic last,
                           input int idle);
    logic ok;
    int n;
    if (idle > 0) begin
      bus.s_valid = 1'b0;
      repeat (idle) tick();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = bus.s_ready;
      if (ok) last_acc_cyc = cyc;
      tick();
      n++;
    end
    chk("accept_in_time", ok, 1'b1);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_seen == d0 && n < 200) begin
      tick();
      n++;
    end
    chk("done_seen", done_seen - d0, 1);
  endtask

  task automatic run_frame(input item_q_t items, input int max_idle);
    int d0;
    int idle;
    d0 = done_seen;
    got_q.delete();
    acc_cyc.delete();
    begin_frame();
    foreach (items[i]) begin
      idle = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
      push_item(items[i], i == items.size() - 1, idle);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    wait_done(d0);
    chk("flush_latency", flush_cyc - last_acc_cyc, 7);
    chk("done_latency", done_cyc - last_acc_cyc, 26);
    tick();
    tick();
    chk("single_done", done_seen - d0, 1);
  endtask

  task automatic check_keys(input string tag, input int keys[$]);
    logic [KW-1:0] g;
    chk({tag, "_n"}, got_q.size(), keys.size());
    foreach (keys[i]) begin
      if (i < got_q.size()) g = got_q[i][KW-1:0];
      else g = 'x;
      chk(tag, g, keys[i]);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  bit used[256];
  initial begin : stim
    item_q_t items;
    int keys[$];
    int d0, n, kk;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    for (int i = 0; i < 6; i++) begin
      tick();
      start       = 1'($urandom);
      abort       = 1'($urandom);
      bus.s_valid = 1'($urandom);
      bus.s_data  = item_t'($urandom);
      bus.s_last  = 1'($urandom);
      check_zero("reset");
    end
    start = 1'b0;
    abort = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    rstn = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", bus.s_ready, 1'b0);

    items.delete();
    items.push_back(mk(1, 5));
    items.push_back(mk(2, 2));
    items.push_back(mk(3, 9));
    run_frame(items, 0);
    keys.delete();
    keys.push_back(2);
    keys.push_back(5);
    keys.push_back(9);
    check_keys("small_keys", keys);
    chk("small_item0", got_q.size() > 0 ? got_q[0] : 'x, mk(2, 2));
    chk("small_in", in_count, 3);
    chk("small_evict", evict_count, 0);
    chk("small_out", out_count, 3);

    items.delete();
    for (int i = 1; i <= 10; i++) items.push_back(mk(i, i));
    run_frame(items, 1);
    keys.delete();
    for (int i = 4; i <= 10; i++) keys.push_back(i);
    check_keys("over_keys", keys);
    chk("over_evict", evict_count, 3);
    chk("over_out", out_count, 7);

    items.delete();
    for (int i = 0; i < 8; i++) items.push_back(mk(i, 40 + 3 * i));
    run_frame(items, 0);
    chk("pace_n", acc_cyc.size(), 8);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("pace_gap", acc_cyc[i] - acc_cyc[i-1], 2);

    d0 = done_seen;
    begin_frame();
    push_item(mk(1, 10), 1'b0, 0);
    push_item(mk(2, 20), 1'b0, 0);
    bus.s_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_load_init", bus.heap_init, 1'b0);
    chk("start_in_load_busy", busy, 1'b1);
    push_item(mk(3, 30), 1'b0, 0);
    bus.s_valid = 1'b0;
    tick();
    chk("pre_abort_in", in_count, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_init", bus.heap_init, 1'b1);
    chk("abort_clear", in_count, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_ready", bus.s_ready, 1'b0);
    end
    chk("abort_init_len", init_len, 8);
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_done", done_seen - d0, 0);

    begin_frame();
    push_item(mk(1, 50), 1'b0, 0);
    push_item(mk(2, 60), 1'b0, 0);
    push_item(mk(3, 70), 1'b1, 0);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    n = 0;
    while (!bus.heap_flush && n < 50) begin
      tick();
      n++;
    end
    chk("saw_flush", bus.heap_flush, 1'b1);
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    check_zero("mid_flush_reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    items.delete();
    items.push_back(mk(7, 3));
    items.push_back(mk(9, 1));
    run_frame(items, 0);
    keys.delete();
    keys.push_back(1);
    keys.push_back(3);
    check_keys("after_reset_keys", keys);

    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(12, 1);
      items.delete();
      foreach (used[k]) used[k] = 1'b0;
      while (items.size() < n) begin
        kk = $urandom_range(255, 0);
        if (!used[kk]) begin
          used[kk] = 1'b1;
          items.push_back(mk($urandom_range(63, 0), kk));
        end
      end
      run_frame(items, 2);
      chk("rand_out_n", got_q.size(), (n < HS) ? n : HS);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/heap_topk_ctrl.md
# heap_topk_ctrl

Frame-level sequencer for the streaming `heap` top-K sorter. It accepts a frame of keyed items (for example keypoint scores) on a valid/ready stream and initialises the heap. It paces insertions at the heap's safe rate, then flushes the heap and forwards the retained K largest items in ascending key order. It sits between the feature-scoring stage and the downstream keypoint selector, and is the only driver of the heap's `init`, `en`, `din` and `flush` inputs.

## Interface
- `DATA_WIDTH`, 16: heap word width, laid out as {2-bit flag, payload, key}.
- `KEY_WIDTH`, 8: key field width in the low bits of the word.
- `NLEVELS`, 2: heap depth. `HEAP_SIZE = 2^(NLEVELS+1) - 1`.
- `INSERT_GAP`, 2: minimum number of cycles between consecutive `heap_en` pulses (must be ≥ 2).
- `INIT_CYCLES`, `HEAP_SIZE + 1`: number of cycles `heap_init` is held high.
- `DRAIN_CYCLES`, `2*NLEVELS + 2`: pipeline settle time after the last insert.
- `FLUSH_CYCLES`, `2*HEAP_SIZE + 4`: length of the flush window.
- `CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`, in, 1: the single clock.
- `rstn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a frame. Sampled only in IDLE.
- `abort`, in, 1: abandon the current frame.
- `s_valid`, in, 1: input item valid.
- `s_ready`, out, 1: input item accepted when `s_valid & s_ready`.
- `s_data`, in, `DATA_WIDTH-2`: {payload, key}.
- `s_last`, in, 1: marks the final item of the frame.
- `heap_din`, out, `DATA_WIDTH`: insert word, equal to {2'b00, s_data}.
- `heap_en`, out, 1: single-cycle insert strobe.
- `heap_init`, out, 1: heap initialise.
- `heap_flush`, out, 1: single-cycle flush strobe.
- `heap_dout`, in, `DATA_WIDTH`: heap output word.
- `heap_valid`, in, 1: heap output valid.
- `m_valid`, out, 1: sorted result valid. There is no backpressure on this port.
- `m_data`, out, `DATA_WIDTH-2`: equal to `heap_dout[DATA_WIDTH-3:0]`.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at frame end.
- `in_count`, out, `CNT_WIDTH`: items accepted in the frame.
- `evict_count`, out, `CNT_WIDTH`: `heap_valid` beats seen during LOAD and DRAIN.
- `out_count`, out, `CNT_WIDTH`: `m_valid` beats seen during FLUSH.

## Operation
- States are IDLE, INIT, LOAD, DRAIN, FLUSH and DONE. Every output is registered.
- IDLE:
  - `start` moves to INIT.
  - On that transition, `in_count`, `evict_count` and `out_count` clear to 0.
- INIT:
  - `heap_init` is high for exactly `INIT_CYCLES` cycles, then the state moves to LOAD.
- LOAD:
  - `s_ready` is 1 only when the gap counter is 0.
  - An accepted beat has these effects on the next cycle:
    - `heap_en` = 1 and `heap_din` = {2'b00, s_data};
    - `in_count` increments;
    - the gap counter loads `INSERT_GAP - 1` and counts down to 0, so `s_ready` stays 0 for `INSERT_GAP - 1` cycles after each accept.
  - An accept with `s_last` = 1 moves the state to DRAIN.
- DRAIN:
  - Lasts `DRAIN_CYCLES` cycles, then the state moves to FLUSH.
  - In both LOAD and DRAIN, `heap_valid` beats are evicted (smaller) items. They are dropped and `evict_count` increments.
- FLUSH:
  - `heap_flush` pulses in the first cycle only.
  - For `FLUSH_CYCLES` cycles the block sets `m_valid` = `heap_valid` and `m_data` = the payload and key of `heap_dout`.
  - Each `m_valid` beat increments `out_count`.
  - After `FLUSH_CYCLES` the state moves to DONE.
- DONE:
  - `done` = 1 for one cycle, then the state returns to IDLE.
  - The counters hold their values until the next `start`.
- Result properties:
  - Forwarded items come out in non-decreasing key order.
  - `out_count` = min(`in_count`, `HEAP_SIZE`).
  - `evict_count` = `in_count` − `out_count`.
- Counters saturate at all-ones and never wrap.
- `abort`, in any state other than IDLE:
  - the next cycle enters INIT with the counters cleared; there is no `done` pulse;
  - INIT then returns to IDLE, not LOAD.
  - `abort` has priority over every other transition.
- Other boundary cases:
  - `start` outside IDLE is ignored.
  - `s_valid` outside LOAD is never accepted.
  - A frame of one beat with `s_last` = 1 is legal.

## Timing
- Reset values: every output is 0 (`s_ready`, `heap_*`, `m_*`, `busy`, `done` and all counters). The state is IDLE and the gap counter is 0.
- Reset asserted mid-frame returns to IDLE immediately. The heap is reset by the same `rstn`.
- `start` at cycle t puts the block in INIT with `heap_init` = 1 from t+1. The first `s_ready` = 1 is at t+1+`INIT_CYCLES`.
- An accept at cycle t gives `heap_en` = 1 at t+1 only. The next accept is possible at t+`INSERT_GAP` at the earliest.
- An accept with `s_last` at cycle t gives `heap_flush` at t+1+`DRAIN_CYCLES` and `done` at t+2+`DRAIN_CYCLES`+`FLUSH_CYCLES`.
- `heap_en` and `heap_flush` are never high in the same cycle.
- `heap_en` is never high in two consecutive cycles.

## Test plan
All scenarios use the default parameters, so `HEAP_SIZE` = 7.
- Reset: hold `rstn` low while driving random inputs → every output is 0. After release with no stimulus, `busy` = 0 and `s_ready` = 0.
- Small frame: `start`, then keys 5, 2, 9 (9 with `s_last`) → `m_data` keys 2, 5, 9 in that order; `in_count` = 3, `evict_count` = 0, `out_count` = 3; `done` pulses once.
- Overfull frame: keys 1 to 10 → forwarded keys 4, 5, 6, 7, 8, 9, 10 ascending; `evict_count` = 3, `out_count` = 7.
- Pacing: `s_valid` held at 1 for 8 beats → accepts exactly every 2 cycles; `heap_en` is never high on adjacent cycles; `heap_din` = {2'b00, s_data}.
- Ignored and abort controls:
  - `start` during LOAD → no effect.
  - `abort` after 3 accepts → `heap_init` is high for 8 cycles, the block returns to IDLE, there is no `done`, and `s_ready` stays 0.
- Reset mid-FLUSH: `rstn` pulsed low during FLUSH → all outputs 0 at once. A following full frame of keys 3, 1 produces 1, 3.
